// File: rtl/demux4_deser.sv
// -----------------------------------------------------------------------------
// demux4_deser
// 4-way demultiplexing deserializer. Elements of W bits arrive one per accept
// and are steered into four lane registers by a 2-bit slot counter (slot n ->
// lane n). A completed group of four, or a flushed partial group, is packed
// into one 4*W word and held in a single-entry valid/ready output buffer.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_data    input element (W bits)
//   in_valid   producer has in_data
//   in_ready   block accepts in_data this cycle
//   flush      single-cycle request to emit a partial group
//   out_data   packed word {lane3, lane2, lane1, lane0}
//   out_count  number of valid lanes in out_data (1..4)
//   out_valid  out_data/out_count valid
//   out_ready  consumer takes the word this cycle
//   lane_sel   one-hot decode of the current slot
// -----------------------------------------------------------------------------
module demux4_deser #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [4*W-1:0]   out_data,
    output logic [2:0]       out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       lane_sel
);

    // State
    logic [1:0]          slot_q, slot_d;
    logic [3:0][W-1:0]   lane_q, lane_d;
    logic [4*W-1:0]      out_data_q, out_data_d;
    logic [2:0]          out_count_q, out_count_d;
    logic                out_valid_q, out_valid_d;

    // Datapath helpers
    logic                accept;
    logic                complete;
    logic                flush_ok;
    logic                flush_emit;
    logic                load;
    logic [2:0]          fill;
    logic [3:0]          lane_we;
    logic [3:0][W-1:0]   merged;
    logic [4*W-1:0]      word;

    assign lane_sel = 4'b0001 << slot_q;

    // Only the group-completing element is held back by a stalled buffer, so
    // the sole combinational path into in_ready comes from out_ready.
    assign in_ready = !((slot_q == 2'd3) && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (slot_q == 2'd3);

    // Lanes filled once any same-edge accept is counted (0..4).
    assign fill     = {1'b0, slot_q} + {2'b00, accept};

    assign flush_ok   = !out_valid_q || out_ready;
    // A completing accept already emits a full word, which absorbs the flush.
    assign flush_emit = flush && !complete && flush_ok && (fill != 3'd0);
    assign load       = complete || flush_emit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = accept && lane_sel[gi];
            // Lane contents as they would be after this edge's write; this is
            // the bypass that lets the 4th element land in the word directly.
            assign merged[gi]  = lane_we[gi] ? in_data : lane_q[gi];
            // Lanes beyond the fill count read as zero in a partial word.
            assign word[gi*W +: W] = (fill > 3'(gi)) ? merged[gi] : '0;
            // Lanes are cleared whenever a word is emitted.
            assign lane_d[gi]  = load ? '0 : merged[gi];
        end
    endgenerate

    always_comb begin
        slot_d      = slot_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        if (load) begin
            slot_d = 2'd0;
        end else if (accept) begin
            slot_d = slot_q + 2'd1;
        end

        if (load) begin
            out_data_d  = word;
            out_count_d = fill;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q      <= 2'd0;
            lane_q      <= '0;
            out_data_q  <= '0;
            out_count_q <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_demux4_deser.sv
module tb_demux4_deser;

    localparam int W = 8;

    logic            clk;
    logic            reset;
    logic [W-1:0]    in_data;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [4*W-1:0]  out_data;
    logic [2:0]      out_count;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      lane_sel;

    int total;
    int bad;

    typedef struct packed {
        logic [4*W-1:0] data;
        logic [2:0]     count;
    } word_t;

    word_t exp_q[$];

    demux4_deser #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane_sel  (lane_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every handshake (seen mid-cycle, consumed at the next edge)
    // is checked against the head of the expected-word queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            word_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got data=%h count=%0d, required none", out_data, out_count);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_count !== e.count) begin
                    bad++;
                    $display("FAIL word: got data=%h count=%0d, required data=%h count=%0d",
                             out_data, out_count, e.data, e.count);
                end else begin
                    $display("word ok: data=%h count=%0d", out_data, out_count);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("check ok: %s = %h", name, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] c);
        word_t e;
        e.data  = d;
        e.count = c;
        exp_q.push_back(e);
    endtask

    // Present one element for one edge (in_ready assumed high).
    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int budget;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_lane_sel", 32'(lane_sel), 32'h1);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back group with lane_sel walking 1,2,4,8,1
        check("sel0", 32'(lane_sel), 32'h1);
        send(8'hA1);
        check("sel1", 32'(lane_sel), 32'h2);
        send(8'hB2);
        check("sel2", 32'(lane_sel), 32'h4);
        send(8'hC3);
        check("sel3", 32'(lane_sel), 32'h8);
        expect_word(32'hD4C3B2A1, 3'd4);
        send(8'hD4);
        check("sel_wrap", 32'(lane_sel), 32'h1);
        check("g1_valid", 32'(out_valid), 32'd1);
        check("g1_data", out_data, 32'hD4C3B2A1);
        step();

        // Stall: hold one word, slots 0..2 still accept, 4th back-pressures
        out_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03);
        expect_word(32'h04030201, 3'd4);
        send(8'h04);
        send(8'h11); send(8'h22); send(8'h33);
        in_valid = 1'b1;
        in_data  = 8'h44;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        step();
        check("stall_hold_data", out_data, 32'h04030201);
        check("stall_hold_sel", 32'(lane_sel), 32'h8);
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 32'(in_ready), 32'd1);
        expect_word(32'h44332211, 3'd4);
        step();
        in_valid = 1'b0;
        check("unstall_data", out_data, 32'h44332211);
        step();

        // Flush after two accepts with buffer empty
        send(8'h55); send(8'h66);
        expect_word(32'h00006655, 3'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush2_count", 32'(out_count), 32'd2);
        check("flush2_sel", 32'(lane_sel), 32'h1);
        step();

        // Flush on the same edge as the 3rd accept
        send(8'h77); send(8'h88);
        expect_word(32'h00998877, 3'd3);
        flush = 1'b1;
        send(8'h99);
        flush = 1'b0;
        check("flush3_data", out_data, 32'h00998877);
        step();

        // Flush on the same edge as the 4th accept: one count-4 word only
        send(8'hAA); send(8'hBB); send(8'hCC);
        expect_word(32'hDDCCBBAA, 3'd4);
        flush = 1'b1;
        send(8'hDD);
        flush = 1'b0;
        check("flush4_count", 32'(out_count), 32'd4);
        step();
        check("flush4_no_extra", 32'(out_valid), 32'd0);

        // Flush with slot 0 and empty buffer: no effect
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle_valid", 32'(out_valid), 32'd0);
        check("flush_idle_sel", 32'(lane_sel), 32'h1);

        // Flush while FULL and stalled: ignored
        out_ready = 1'b0;
        send(8'hEE); send(8'hFF); send(8'h10);
        expect_word(32'h2010FFEE, 3'd4);
        send(8'h20);
        send(8'h30);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_full_valid", 32'(out_valid), 32'd1);
        check("flush_full_data", out_data, 32'h2010FFEE);
        check("flush_full_sel", 32'(lane_sel), 32'h2);
        out_ready = 1'b1;
        step();
        // Re-asserted flush now emits the pending single element
        expect_word(32'h00000030, 3'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();

        // Asynchronous reset mid-group with a held word
        out_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03);
        expect_word(32'h04030201, 3'd4);
        send(8'h04);
        send(8'h05); send(8'h06); send(8'h07);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_sel", 32'(lane_sel), 32'h1);
        exp_q.delete();
        #2;
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        send(8'h08); send(8'h09); send(8'h0A);
        expect_word(32'h0B0A0908, 3'd4);
        send(8'h0B);
        check("arst_new_data", out_data, 32'h0B0A0908);

        // Drain, bounded
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            step();
            budget++;
        end
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
